// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: single-outstanding imem requests, decode handshake, J/BEQ redirects.
// Optional clean fetch stop is compiled in with `define PC_HALT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        jump_valid,
  input  logic [1:0]  jump_op,
  input  logic [31:0] jump_pc,
  input  logic [25:0] jump_imm26,
  input  logic [15:0] jump_imm16,
  input  logic        halt_i,
  output logic        halted,
  output logic        redirect
);

  // state | meaning
  // FETCH | request at imem_addr in flight or about to issue
  // HOLD  | instruction buffered, waiting for decode to accept
  // HALT  | fetch stopped until reset (PC_HALT_EN only)
  typedef enum logic [1:0] {
    FETCH = 2'd0,
`ifdef PC_HALT_EN
    HALT  = 2'd2,
`endif
    HOLD  = 2'd1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        pending_q, pending_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        redirect_q, redirect_d;
  logic        halting;
  logic        redirect_req;
  logic [31:0] target;
  logic        unused_inputs;

  assign unused_inputs = ^{jump_imm26[25:9], halt_i};

`ifdef PC_HALT_EN
  logic halt_q, halt_d;
  assign halt_d  = halt_q | halt_i;
  assign halting = halt_q | halt_i;
  assign halted  = (state_q == HALT);
  always_ff @(posedge clk) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end
`else
  assign halting = 1'b0;
  assign halted  = 1'b0;
`endif

  assign redirect_req = jump_valid && jump_op[1];
  assign target = jump_op[0] ? (jump_pc + 32'd1 + {{16{jump_imm16[15]}}, jump_imm16})
                             : {23'b0, jump_imm26[8:0]};

  // Once a request is out it stays out until acked, even if halt arrives.
  assign imem_req   = rst_n && (state_q == FETCH) && (pending_q || !halting);
  // While dropping, the address of the in-flight request is frozen in addr_q.
  assign imem_addr  = drop_q ? addr_q : pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign redirect   = redirect_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = imem_addr;
    drop_d       = drop_q;
    pending_d    = 1'b0;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    redirect_d   = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_req && imem_ack) begin
          if (redirect_req) begin
            pc_d       = target;
            drop_d     = 1'b0;
            redirect_d = 1'b1;
          end else if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd1;
            state_d      = HOLD;
          end
        end else begin
          pending_d = imem_req;
          if (redirect_req) begin
            pc_d       = target;
            redirect_d = 1'b1;
            if (imem_req) drop_d = 1'b1;
          end
`ifdef PC_HALT_EN
          else if (!imem_req && halting) begin
            state_d = HALT;
          end
`endif
        end
      end
      HOLD: begin
        if (redirect_req) begin
          pc_d         = target;
          inst_valid_d = 1'b0;
          redirect_d   = 1'b1;
          state_d      = FETCH;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
`ifdef PC_HALT_EN
          state_d = halting ? HALT : FETCH;
`else
          state_d = FETCH;
`endif
        end
      end
`ifdef PC_HALT_EN
      HALT: begin
        state_d = HALT;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      drop_q       <= 1'b0;
      pending_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      redirect_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      pending_q    <= pending_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      redirect_q   <= redirect_d;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the fetch stage. It owns the word-addressed PC register and drives single-outstanding requests to instruction memory. It hands fetched instructions to decode through a valid/ready handshake and applies jump/branch redirects from execute (J and taken BEQ), squashing wrong-path fetches. An optional halt path stops fetching cleanly.

## Interface
- RESET_PC, 32'h0000_0000, word address fetched first after reset
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  word address of the request; stable while imem_req high
- imem_ack  in  1  request complete, imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst  out  32  instruction to decode
- inst_pc  out  32  word address of inst
- inst_ready  in  1  decode accepts inst when inst_valid && inst_ready
- jump_valid  in  1  execute presents a resolved control op this cycle
- jump_op  in  2  00/01 sequential (no redirect), 10 J, 11 BEQ taken
- jump_pc  in  32  word address of the jumping instruction
- jump_imm26  in  26  J immediate
- jump_imm16  in  16  BEQ offset, in words
- halt_i  in  1  stop fetching (only with PC_HALT_EN)
- halted  out  1  fetch stopped
- redirect  out  1  one-cycle pulse: redirect accepted

## Operation
- FSM states: FETCH, HOLD, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with no drop pending: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+1, go to HOLD.
- HOLD:
  - imem_req=0.
  - On inst_valid && inst_ready: inst_valid<=0, go to FETCH.
- Redirect condition: jump_valid && jump_op[1]. Target:
  - J: {23'b0, jump_imm26[8:0]}.
  - BEQ: jump_pc + 1 + sign-extended jump_imm16, 32-bit wrap-around.
- Redirect action, taken in any state except HALT:
  - pc<=target, inst_valid<=0, redirect<=1 for one cycle.
  - State goes to FETCH, or stays in FETCH.
- Redirect while a request is outstanding (imem_req=1, no ack yet):
  - imem_req stays high with the old address until ack, because the address must not change mid-request.
  - Set drop flag. On the ack: discard data, clear drop, stay in FETCH, issue target next cycle.
- Simultaneous redirect and imem_ack: data discarded, pc<=target, next cycle requests target. Drop flag not set.
- Simultaneous redirect and inst handshake: redirect wins; decode's acceptance stands, buffer cleared.
- jump_valid with jump_op 00/01: no state change.
- Arithmetic: pc+1 wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, redirect=0, pc=RESET_PC, drop=0, state FETCH.
- First imem_req=1 in the first cycle with rst_n=1.
- Fetch latency: inst_valid rises the cycle after imem_ack. Steady-state throughput is one instruction per 2 cycles plus memory latency.
- Redirect: pc/target visible on imem_addr the cycle after jump_valid, unless a request is outstanding (then the cycle after its ack). redirect pulses in the cycle after jump_valid.
- rst_n low in any state, including mid-request: everything returns to reset values next edge. The ack of the abandoned request is not tracked.

## Configuration
- PC_HALT_EN defined:
  - halt_i high in FETCH with no outstanding request, or in HOLD: no new request is issued.
  - An outstanding request completes, and its data is delivered unless dropped.
  - After the buffer empties (inst_valid=0), enter HALT with halted=1.
  - HALT exits only on reset; redirects are ignored in HALT.
- PC_HALT_EN undefined: halt_i ignored, halted tied 0, no HALT state.

## Test plan
- Reset with RESET_PC=0x10, memory ack after 1 cycle, inst_ready=1 -> addresses 0x10, 0x11, 0x12 with matching inst_pc; first req in cycle 1 after reset release.
- inst_ready held low 5 cycles with inst_valid=1 -> imem_req stays 0, inst/inst_pc stable; after accept, next address = previous+1.
- J with jump_imm26=0x3FF_FF05 -> next imem_addr=0x105, redirect pulse 1 cycle, buffered inst squashed.
- BEQ with jump_pc=0x20, imm16=0xFFFC while a request to 0x22 is outstanding with ack 3 cycles later -> 0x22 data discarded (no inst_valid), next request 0x1D.
- Redirect in the same cycle as imem_ack -> no inst_valid, next cycle imem_addr=target; pc=0xFFFF_FFFF fetch -> next address 0.
- With PC_HALT_EN: halt_i during outstanding fetch -> instruction delivered, halted=1 after accept, no further imem_req; a later J is ignored.
